// File: rtl/hi_fanin_pkg.sv
// Shared types and elaboration-time helpers for the hi_fanin_reduce reduction tree.
package hi_fanin_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2
    } op_e;

    // Number of tree levels needed to collapse n inputs with radix-wide nodes.
    function automatic int num_levels(int n, int radix);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        for (int i = 0; i < 32; i++) begin
            if (span < n) begin
                span = span * radix;
                lv   = lv + 1;
            end
        end
        return lv;
    endfunction

    function automatic int level_width(int n, int radix, int k);
        int w;
        w = n;
        for (int i = 0; i < k; i++) w = (w + radix - 1) / radix;
        return w;
    endfunction

    // Partial-count width at level k: enough for min(n, radix^k) set bits.
    function automatic int cnt_width(int n, int radix, int k);
        int span;
        span = 1;
        for (int i = 0; i < k; i++) begin
            if (span < n) span = span * radix;
        end
        if (span > n) span = n;
        return $clog2(span + 1);
    endfunction

    function automatic logic identity(op_e op);
        return (op == OP_AND);
    endfunction

endpackage

// File: rtl/hi_fanin_node.sv
// One registered RADIX-input tree node: bit reduction plus, with HI_FANIN_POPCNT_EN
// defined, a registered partial population count.
module hi_fanin_node
    import hi_fanin_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int OP    = 0,
    parameter int CIW   = 1,
    parameter int COW   = 3
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [RADIX-1:0]     i_bits,
    input  logic [RADIX*CIW-1:0] i_cnt,
    output logic                 o_bit,
    output logic [COW-1:0]       o_cnt
);

    logic w_red;
    logic r_bit;

    // NOTE: the accumulator is seeded before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        w_red = identity(op_e'(OP));
        for (int i = 0; i < RADIX; i++) begin
            case (op_e'(OP))
                OP_AND:  w_red = w_red & i_bits[i];
                OP_XOR:  w_red = w_red ^ i_bits[i];
                default: w_red = w_red | i_bits[i];
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so all nodes sample the previous level together.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_bit <= 1'b0;
        end else if (i_en) begin
            r_bit <= w_red;
        end
    end

    assign o_bit = r_bit;

`ifdef HI_FANIN_POPCNT_EN
    logic [COW-1:0] w_sum;
    logic [COW-1:0] r_cnt;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < RADIX; i++) begin
            w_sum = w_sum + COW'(i_cnt[i*CIW +: CIW]);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_sum;
        end
    end

    assign o_cnt = r_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^i_cnt;
    assign o_cnt        = '0;
`endif

endmodule

// File: rtl/hi_fanin_reduce.sv
// Pipelined N_IN-input OR/AND/XOR reduction tree with a global-stall handshake.
// Define HI_FANIN_POPCNT_EN to build the parallel population-count tree; otherwise out_count is 0.
module hi_fanin_reduce
    import hi_fanin_pkg::*;
#(
    parameter int N_IN  = 70,
    parameter int RADIX = 4,
    parameter int OP    = 0
) (
    input  logic                      clk1,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN-1:0]           in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_data,
    output logic [$clog2(N_IN+1)-1:0] out_count
);

    localparam int   LEVELS  = num_levels(N_IN, RADIX);
    localparam int   CNT_W   = $clog2(N_IN + 1);
    localparam logic PAD_BIT = identity(op_e'(OP));

    if (OP < 0 || OP > 2) begin : g_bad_op
        $error("hi_fanin_reduce: OP must be 0 (OR), 1 (AND) or 2 (XOR)");
    end
    if (RADIX < 2 || RADIX > 8 || N_IN < 2) begin : g_bad_shape
        $error("hi_fanin_reduce: need RADIX in 2..8 and N_IN >= 2");
    end

    logic              w_stall;
    logic [LEVELS:0]   r_valid;
    logic [N_IN-1:0]   r_s0_data;

    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_valid[LEVELS];

    // Valids shift every unstalled cycle, so bubbles travel with the data instead of collapsing.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_s0_data <= '0;
        end else if (!w_stall) begin
            r_valid   <= {r_valid[LEVELS-1:0], in_valid};
            r_s0_data <= in_data;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N_PREV = level_width(N_IN, RADIX, k - 1);
        localparam int N_CUR  = level_width(N_IN, RADIX, k);
        localparam int CIW    = cnt_width(N_IN, RADIX, k - 1);
        localparam int COW    = cnt_width(N_IN, RADIX, k);

        logic [N_PREV-1:0]     w_src_bits;
        logic [N_PREV*CIW-1:0] w_src_cnt;
        logic [N_CUR-1:0]      w_bits;
        logic [N_CUR*COW-1:0]  w_cnt;

        if (k == 1) begin : g_src
            assign w_src_bits = r_s0_data;
            assign w_src_cnt  = r_s0_data;
        end else begin : g_src
            assign w_src_bits = g_lvl[k-1].w_bits;
            assign w_src_cnt  = g_lvl[k-1].w_cnt;
        end

        for (genvar n = 0; n < N_CUR; n++) begin : g_node
            logic [RADIX-1:0]     w_in_bits;
            logic [RADIX*CIW-1:0] w_in_cnt;

            // Slots past the last real source get the operator identity and a zero count.
            for (genvar r = 0; r < RADIX; r++) begin : g_pad
                if (n * RADIX + r < N_PREV) begin : g_real
                    assign w_in_bits[r]             = w_src_bits[n*RADIX+r];
                    assign w_in_cnt[r*CIW +: CIW]   = w_src_cnt[(n*RADIX+r)*CIW +: CIW];
                end else begin : g_fill
                    assign w_in_bits[r]             = PAD_BIT;
                    assign w_in_cnt[r*CIW +: CIW]   = '0;
                end
            end

            hi_fanin_node #(
                .RADIX (RADIX),
                .OP    (OP),
                .CIW   (CIW),
                .COW   (COW)
            ) u_node (
                .clk1   (clk1),
                .rst_n  (rst_n),
                .i_en   (~w_stall),
                .i_bits (w_in_bits),
                .i_cnt  (w_in_cnt),
                .o_bit  (w_bits[n]),
                .o_cnt  (w_cnt[n*COW +: COW])
            );
        end
    end

    assign out_data  = g_lvl[LEVELS].w_bits[0];
    assign out_count = CNT_W'(g_lvl[LEVELS].w_cnt);

endmodule

// File: tb/tb_hi_fanin_reduce.sv
// Self-checking bench: OR, AND and XOR instances share stimulus and are compared
// against a token/age reference model of the pipeline.
module tb_hi_fanin_reduce;

    localparam int N   = 70;
    localparam int CW  = 7;
    localparam int LAT = 5;

    typedef struct {
        logic [N-1:0] data;
        int           age;
    } tok_t;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [N-1:0]  in_data = '0;

    logic          rdy_or, rdy_and, rdy_xor;
    logic          ov_or, ov_and, ov_xor;
    logic          od_or, od_and, od_xor;
    logic [CW-1:0] oc_or, oc_and, oc_xor;

    tok_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk1 = ~clk1;

    hi_fanin_reduce #(.N_IN(N), .RADIX(4), .OP(0)) u_or (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_or), .in_data(in_data),
        .out_valid(ov_or), .out_ready(out_ready), .out_data(od_or), .out_count(oc_or));
    hi_fanin_reduce #(.N_IN(N), .RADIX(4), .OP(1)) u_and (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_and), .in_data(in_data),
        .out_valid(ov_and), .out_ready(out_ready), .out_data(od_and), .out_count(oc_and));
    hi_fanin_reduce #(.N_IN(N), .RADIX(4), .OP(2)) u_xor (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_xor), .in_data(in_data),
        .out_valid(ov_xor), .out_ready(out_ready), .out_data(od_xor), .out_count(oc_xor));

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_count(input logic [N-1:0] d);
`ifdef HI_FANIN_POPCNT_EN
        return $countones(d);
`else
        return (d === d) ? 0 : 0;
`endif
    endfunction

    function automatic logic [N-1:0] rand_data();
        logic [95:0]  t;
        logic [N-1:0] d;
        t = {$urandom(), $urandom(), $urandom()};
        d = t[N-1:0];
        case ($urandom_range(0, 3))
            0: return d;
            1: return '1;
            2: begin d = '1; d[$urandom_range(0, N-1)] = 1'b0; return d; end
            default: begin d = '0; d[$urandom_range(0, N-1)] = 1'b1; return d; end
        endcase
    endfunction

    task automatic check_outputs(input logic exp_ov, input logic exp_stall);
        logic [N-1:0] d;
        chk("in_ready_or",  rdy_or,  !exp_stall);
        chk("in_ready_and", rdy_and, !exp_stall);
        chk("in_ready_xor", rdy_xor, !exp_stall);
        chk("out_valid_or",  ov_or,  exp_ov);
        chk("out_valid_and", ov_and, exp_ov);
        chk("out_valid_xor", ov_xor, exp_ov);
        if (exp_ov) begin
            d = sb[0].data;
            chk("data_or",  od_or,  |d);
            chk("data_and", od_and, &d);
            chk("data_xor", od_xor, ^d);
            chk("count_or",  oc_or,  exp_count(d));
            chk("count_and", oc_and, exp_count(d));
            chk("count_xor", oc_xor, exp_count(d));
        end
    endtask

    // Checks the cycle's outputs, advances the model across the next edge, then waits for it.
    task automatic step();
        logic exp_ov;
        logic exp_stall;
        tok_t t;
        #1;
        exp_ov    = (sb.size() > 0) && (sb[0].age == LAT);
        exp_stall = exp_ov && !out_ready;
        check_outputs(exp_ov, exp_stall);
        if (!exp_stall) begin
            if (exp_ov) void'(sb.pop_front());
            foreach (sb[i]) sb[i].age++;
            if (in_valid) begin
                t.data = in_data;
                t.age  = 1;
                sb.push_back(t);
            end
        end
        @(posedge clk1);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int budget;
        budget = 40;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic send(input logic [N-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        drain();
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready",  rdy_or & rdy_and & rdy_xor, 1);
        chk("rst_out_valid", ov_or | ov_and | ov_xor, 0);
        chk("rst_out_data",  od_or | od_and | od_xor, 0);
        chk("rst_out_count", oc_or | oc_and | oc_xor, 0);
    endtask

    initial begin
        logic [N-1:0] d;
        logic [N-1:0] toks [8];
        int           sent;

        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(posedge clk1);
        #1 check_reset_values();
        #3 rst_n = 1'b1;
        @(posedge clk1);
        #1;

        // Directed patterns
        send('0);
        d = '0; d[69] = 1'b1; send(d);
        d = '0; d[0]  = 1'b1; send(d);
        send('1);
        d = '1; d[35] = 1'b0; send(d);
        d = '0; d[3] = 1'b1; d[40] = 1'b1; d[68] = 1'b1; send(d);
        d = '0; d[3] = 1'b1; d[40] = 1'b1; send(d);

        // Eight back-to-back tokens with a 3-cycle sink stall in the middle
        for (int i = 0; i < 8; i++) toks[i] = rand_data();
        sent = 0;
        for (int c = 0; c < 30 && sent < 8; c++) begin
            out_ready = !(c >= 6 && c <= 8);
            in_valid  = 1'b1;
            in_data   = toks[sent];
            if (!((sb.size() > 0) && (sb[0].age == LAT) && !out_ready)) sent++;
            step();
        end
        chk("b2b_sent", sent, 8);
        drain();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = rand_data();
            step();
        end
        drain();

        // Reset with tokens in flight and a result held at the output
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = '1;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_valid", ov_or, 1);
        rst_n = 1'b0;
        #1 check_reset_values();
        sb.delete();
        #2 rst_n = 1'b1;
        @(posedge clk1);
        #1;
        out_ready = 1'b1;
        d = '0; d[10] = 1'b1; d[20] = 1'b1;
        send(d);
        for (int i = 0; i < 10; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
